// File: rtl/mcash_chn_arb_if.sv
// Signal bundle between the mcash channel arbiter (slave view) and its
// requesting channels plus the core pipeline (master view).
interface mcash_chn_arb_if #(
  parameter int CH_NUM = 3,
  parameter int OP_W   = 3,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [CH_NUM-1:0]        ch_req_valid_i;
  logic [CH_NUM-1:0]        ch_req_allowIn_o;
  logic [CH_NUM*OP_W-1:0]   ch_req_op_i;
  logic [CH_NUM*ADDR_W-1:0] ch_req_addr_i;
  logic [CH_NUM*DATA_W-1:0] ch_req_data_i;

  logic [CH_NUM-1:0]        ch_rtn_valid_o;
  logic [CH_NUM-1:0]        ch_rtn_ready_i;
  logic [DATA_W-1:0]        ch_rtn_data_o;

  logic                     core_req_valid_o;
  logic                     core_req_allowIn_i;
  logic [OP_W-1:0]          core_req_op_o;
  logic [ADDR_W-1:0]        core_req_addr_o;
  logic [DATA_W-1:0]        core_req_data_o;
  logic [CH_W-1:0]          core_req_ch_o;

  logic                     core_rtn_valid_i;
  logic                     core_rtn_ready_o;
  logic [DATA_W-1:0]        core_rtn_data_i;

  modport slave (
    input  ch_req_valid_i, ch_req_op_i, ch_req_addr_i, ch_req_data_i,
    output ch_req_allowIn_o,
    input  ch_rtn_ready_i,
    output ch_rtn_valid_o, ch_rtn_data_o,
    input  core_req_allowIn_i,
    output core_req_valid_o, core_req_op_o, core_req_addr_o, core_req_data_o, core_req_ch_o,
    input  core_rtn_valid_i, core_rtn_data_i,
    output core_rtn_ready_o
  );

  modport master (
    output ch_req_valid_i, ch_req_op_i, ch_req_addr_i, ch_req_data_i,
    input  ch_req_allowIn_o,
    output ch_rtn_ready_i,
    input  ch_rtn_valid_o, ch_rtn_data_o,
    output core_req_allowIn_i,
    input  core_req_valid_o, core_req_op_o, core_req_addr_o, core_req_data_o, core_req_ch_o,
    output core_rtn_valid_i, core_rtn_data_i,
    input  core_rtn_ready_o
  );
endinterface

// File: rtl/mcash_chn_arb.sv
// N-channel request arbiter with outstanding-tag FIFO that routes in-order core returns back to
// their issuing channel. Define MCASH_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mcash_chn_arb #(
  parameter int CH_NUM     = 3,
  parameter int OP_W       = 3,
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int OSTD_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mcash_chn_arb_if.slave bus
);

  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int PTR_W = $clog2(OSTD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              load;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   head_ch;
  logic [CH_NUM-1:0] allow_in;
  logic [CH_NUM-1:0] rtn_valid;
  logic              rtn_ready;

  logic              req_valid_q, req_valid_d;
  logic [OP_W-1:0]   req_op_q,    req_op_d;
  logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
  logic [DATA_W-1:0] req_data_q,  req_data_d;
  logic [CH_W-1:0]   req_ch_q,    req_ch_d;

  logic [CH_W-1:0]   tag_q [OSTD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  assign load       = ~req_valid_q | bus.core_req_allowIn_i;
  assign fifo_full  = (cnt_q == CNT_W'(OSTD_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // Reset is folded in so no channel sees allowIn while the block is held in reset.
  assign accept     = rst_i & load & ~fifo_full & grant_vld;
  assign push       = accept;

`ifdef MCASH_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (bus.ch_req_valid_i[i]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(i);
      end
    end
  end
`else
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  int              rr_idx;

  // Scanning offsets downward leaves the closest valid channel at or after rr_ptr as the winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    rr_idx    = 0;
    for (int off = CH_NUM - 1; off >= 0; off--) begin
      rr_idx = int'(rr_ptr_q) + off;
      if (rr_idx >= CH_NUM) rr_idx = rr_idx - CH_NUM;
      if (bus.ch_req_valid_i[rr_idx]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(rr_idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (grant_ch == CH_W'(CH_NUM - 1)) ? '0 : grant_ch + CH_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    allow_in = '0;
    if (accept) allow_in[grant_ch] = 1'b1;
  end

  always_comb begin
    req_valid_d = req_valid_q;
    req_op_d    = req_op_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_ch_d    = req_ch_q;
    if (accept) begin
      req_valid_d = 1'b1;
      req_op_d    = bus.ch_req_op_i[int'(grant_ch)*OP_W +: OP_W];
      req_addr_d  = bus.ch_req_addr_i[int'(grant_ch)*ADDR_W +: ADDR_W];
      req_data_d  = bus.ch_req_data_i[int'(grant_ch)*DATA_W +: DATA_W];
      req_ch_d    = grant_ch;
    end else if (load) begin
      req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_valid_q <= 1'b0;
      req_op_q    <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_ch_q    <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_op_q    <= req_op_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_ch_q    <= req_ch_d;
    end
  end

  // Returns arrive in issue order, so the FIFO head always names the owner of the current return.
  assign head_ch   = tag_q[rd_ptr_q];
  assign rtn_ready = ~fifo_empty & bus.ch_rtn_ready_i[head_ch];
  assign pop       = bus.core_rtn_valid_i & rtn_ready;

  always_comb begin
    rtn_valid = '0;
    if (bus.core_rtn_valid_i && !fifo_empty) rtn_valid[head_ch] = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < OSTD_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) tag_q[wr_ptr_q] <= grant_ch;
    end
  end

  assign bus.ch_req_allowIn_o = allow_in;
  assign bus.core_req_valid_o = req_valid_q;
  assign bus.core_req_op_o    = req_op_q;
  assign bus.core_req_addr_o  = req_addr_q;
  assign bus.core_req_data_o  = req_data_q;
  assign bus.core_req_ch_o    = req_ch_q;
  assign bus.ch_rtn_valid_o   = rtn_valid;
  assign bus.ch_rtn_data_o    = bus.core_rtn_data_i;
  assign bus.core_rtn_ready_o = rtn_ready;

endmodule
